// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - SDRAM command encodings and arbiter state encoding
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  // One-hot arbiter states
  typedef enum logic [4:0] {
    ST_INIT  = 5'b00001,
    ST_ARB   = 5'b00010,
    ST_AREF  = 5'b00100,
    ST_WRITE = 5'b01000,
    ST_READ  = 5'b10000
  } arb_state_e;

endpackage

// File: rtl/sdram_watchdog.sv
// rtl/sdram_watchdog.sv - ownership watchdog counter with clear, enable and expire
module sdram_watchdog #(
  parameter int MAX = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Expire fires on the MAX-th enabled cycle since the last clear
  assign expire = en && (count_q == LAST);

  // Next count: clear wins, hold once expired so the owner is released
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expire) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - SDRAM bus arbiter for init, refresh, write and read sources
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic        sclk,
  input  logic        s_rst,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic        ref_req,
  input  logic        ref_end,
  input  logic [3:0]  ref_cmd,
  input  logic [11:0] ref_addr,
  output logic        ref_en,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_bank,
  output logic        wr_en,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_bank,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_ba,
  output logic        err_timeout
);

  arb_state_e  state_q, state_d;
  logic        last_rd_q, last_rd_d;
  logic        ref_en_q, ref_en_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [11:0] addr_q, addr_d;
  logic [1:0]  ba_q, ba_d;
  logic        cke_q;
  logic        err_q, err_d;
  logic        owner;
  logic        wd_expire;

  assign owner = (state_q == ST_AREF) || (state_q == ST_WRITE) || (state_q == ST_READ);

  // Clearing outside owner states restarts the count on every new ownership
  sdram_watchdog #(.MAX(TIMEOUT)) u_watchdog (
    .clk    (sclk),
    .rst    (s_rst),
    .clr    (!owner),
    .en     (owner),
    .expire (wd_expire)
  );

  // Grant selection, owner release and the per-state command/address mux
  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    ref_en_d  = 1'b0;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    err_d     = err_q;
    cmd_d     = CMD_NOP;
    addr_d    = '0;
    ba_d      = '0;
    case (state_q)
      ST_INIT: begin
        cmd_d  = init_cmd;
        addr_d = init_addr;
        if (init_end) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (ref_req) begin
          state_d  = ST_AREF;
          ref_en_d = 1'b1;
        end else if (wr_req && (!rd_req || last_rd_q)) begin
          state_d   = ST_WRITE;
          wr_en_d   = 1'b1;
          last_rd_d = 1'b0;
        end else if (rd_req) begin
          state_d   = ST_READ;
          rd_en_d   = 1'b1;
          last_rd_d = 1'b1;
        end
      end
      ST_AREF: begin
        cmd_d  = ref_cmd;
        addr_d = ref_addr;
        if (ref_end) state_d = ST_ARB;
      end
      ST_WRITE: begin
        cmd_d  = wr_cmd;
        addr_d = wr_addr;
        ba_d   = wr_bank;
        if (wr_end) state_d = ST_ARB;
      end
      ST_READ: begin
        cmd_d  = rd_cmd;
        addr_d = rd_addr;
        ba_d   = rd_bank;
        if (rd_end) state_d = ST_ARB;
      end
      default: state_d = ST_INIT;
    endcase
    // A stuck owner is forcibly released with a NOP and a sticky error
    if (wd_expire) begin
      state_d = ST_ARB;
      cmd_d   = CMD_NOP;
      addr_d  = '0;
      ba_d    = '0;
      err_d   = 1'b1;
    end
  end

  // State, grant pulses and registered SDRAM pins
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q   <= ST_INIT;
      last_rd_q <= 1'b1;
      ref_en_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      cmd_q     <= CMD_NOP;
      addr_q    <= '0;
      ba_q      <= '0;
      cke_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      ref_en_q  <= ref_en_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      ba_q      <= ba_d;
      cke_q     <= 1'b1;
      err_q     <= err_d;
    end
  end

  assign ref_en      = ref_en_q;
  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign sdram_cke   = cke_q;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
  assign sdram_addr  = addr_q;
  assign sdram_ba    = ba_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench for sdram_arbiter
module tb_sdram_arbiter;
  import sdram_pkg::*;

  logic        sclk;
  logic        s_rst;
  logic        init_end;
  logic [3:0]  init_cmd;
  logic [11:0] init_addr;
  logic        ref_req, ref_end, ref_en;
  logic [3:0]  ref_cmd;
  logic [11:0] ref_addr;
  logic        wr_req, wr_end, wr_en;
  logic [3:0]  wr_cmd;
  logic [11:0] wr_addr;
  logic [1:0]  wr_bank;
  logic        rd_req, rd_end, rd_en;
  logic [3:0]  rd_cmd;
  logic [11:0] rd_addr;
  logic [1:0]  rd_bank;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic        err_timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [2:0]  exp_grant_q[$];
  logic [17:0] exp_pin_q[$];

  logic [17:0] pins;
  logic [3:0]  cmd_pins;
  assign pins     = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_addr, sdram_ba};
  assign cmd_pins = pins[17:14];

  sdram_arbiter #(.TIMEOUT(16)) dut (
    .sclk        (sclk),
    .s_rst       (s_rst),
    .init_end    (init_end),
    .init_cmd    (init_cmd),
    .init_addr   (init_addr),
    .ref_req     (ref_req),
    .ref_end     (ref_end),
    .ref_cmd     (ref_cmd),
    .ref_addr    (ref_addr),
    .ref_en      (ref_en),
    .wr_req      (wr_req),
    .wr_end      (wr_end),
    .wr_cmd      (wr_cmd),
    .wr_addr     (wr_addr),
    .wr_bank     (wr_bank),
    .wr_en       (wr_en),
    .rd_req      (rd_req),
    .rd_end      (rd_end),
    .rd_cmd      (rd_cmd),
    .rd_addr     (rd_addr),
    .rd_bank     (rd_bank),
    .rd_en       (rd_en),
    .sdram_cke   (sdram_cke),
    .sdram_cs_n  (sdram_cs_n),
    .sdram_ras_n (sdram_ras_n),
    .sdram_cas_n (sdram_cas_n),
    .sdram_we_n  (sdram_we_n),
    .sdram_addr  (sdram_addr),
    .sdram_ba    (sdram_ba),
    .err_timeout (err_timeout)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic idle_inputs();
    init_end = 1'b0; init_cmd = CMD_NOP; init_addr = '0;
    ref_req = 1'b0; ref_end = 1'b0; ref_cmd = CMD_AREF; ref_addr = 12'h055;
    wr_req = 1'b0; wr_end = 1'b0; wr_cmd = CMD_WR; wr_addr = 12'h1FF; wr_bank = 2'd2;
    rd_req = 1'b0; rd_end = 1'b0; rd_cmd = CMD_RD; rd_addr = 12'h123; rd_bank = 2'd3;
  endtask

  task automatic do_reset_init();
    s_rst = 1'b1;
    idle_inputs();
    tick(); tick();
    s_rst = 1'b0;
    init_end = 1'b1;
    tick(); tick();
  endtask

  task automatic wait_grant(input int budget, output logic [2:0] code, output int at);
    code = 3'b000;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ({rd_en, wr_en, ref_en} != 3'b000) begin
        code = {rd_en, wr_en, ref_en};
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic early_en;
    early_en = 1'b0;
    s_rst = 1'b1;
    idle_inputs();
    init_cmd = CMD_PRE; init_addr = 12'h400;
    ref_req = 1'b1;
    repeat (3) tick();
    total++; if ({ref_en, wr_en, rd_en} !== 3'b000) begin bad++; $display("FAIL rst_en: got %b want 000", {ref_en, wr_en, rd_en}); end
    total++; if (cmd_pins !== CMD_NOP) begin bad++; $display("FAIL rst_cmd: got %b want %b", cmd_pins, CMD_NOP); end
    total++; if ({sdram_addr, sdram_ba} !== 14'd0) begin bad++; $display("FAIL rst_addr: got %h want 0", {sdram_addr, sdram_ba}); end
    total++; if (sdram_cke !== 1'b0) begin bad++; $display("FAIL rst_cke: got %b want 0", sdram_cke); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err_timeout); end
    s_rst = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) begin
        total++; if (sdram_cke !== 1'b1) begin bad++; $display("FAIL cke_rise: got %b want 1", sdram_cke); end
      end
      if (c <= 11 && {ref_en, wr_en, rd_en} != 3'b000) early_en = 1'b1;
      if (c == 10) init_end = 1'b1;
      if (c == 11) begin
        total++; if ({cmd_pins, sdram_addr} !== {CMD_PRE, 12'h400}) begin bad++; $display("FAIL init_pins: got %h want %h", {cmd_pins, sdram_addr}, {CMD_PRE, 12'h400}); end
      end
      if (c == 12) begin
        total++; if ({ref_en, wr_en, rd_en} !== 3'b100) begin bad++; $display("FAIL first_grant: got %b want 100", {ref_en, wr_en, rd_en}); end
        total++; if (cmd_pins !== CMD_NOP) begin bad++; $display("FAIL arb_nop: got %b want %b", cmd_pins, CMD_NOP); end
        ref_req = 1'b0; ref_end = 1'b1;
      end
      if (c == 13) begin
        ref_end = 1'b0;
        total++; if ({cmd_pins, sdram_addr} !== {CMD_AREF, 12'h055}) begin bad++; $display("FAIL aref_pins: got %h want %h", {cmd_pins, sdram_addr}, {CMD_AREF, 12'h055}); end
      end
    end
    total++; if (early_en !== 1'b0) begin bad++; $display("FAIL early_grant: got %b want 0", early_en); end
    tick(); tick();
  endtask

  task automatic test_priority();
    logic [2:0] code, exp;
    int at, prev_end;
    prev_end = -1;
    exp_grant_q.push_back(3'b001);
    exp_grant_q.push_back(3'b010);
    exp_grant_q.push_back(3'b100);
    ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    while (exp_grant_q.size() > 0) begin
      wait_grant(40, code, at);
      exp = exp_grant_q.pop_front();
      total++; if (code !== exp) begin bad++; $display("FAIL prio_order: got %b want %b", code, exp); end
      total++; if (cmd_pins !== CMD_NOP) begin bad++; $display("FAIL prio_gap_nop: got %b want %b", cmd_pins, CMD_NOP); end
      if (prev_end >= 0) begin
        total++; if (at - prev_end != 2) begin bad++; $display("FAIL prio_gap_len: got %0d want 2", at - prev_end); end
      end
      tick();
      case (code)
        3'b001: begin ref_req = 1'b0; ref_end = 1'b1; end
        3'b010: begin wr_req = 1'b0; wr_end = 1'b1; end
        3'b100: begin rd_req = 1'b0; rd_end = 1'b1; end
        default: ;
      endcase
      prev_end = cyc;
      tick();
      ref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
    end
    ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_alternate();
    logic [2:0] code, exp;
    int at;
    do_reset_init();
    exp_grant_q.push_back(3'b010);
    exp_grant_q.push_back(3'b100);
    exp_grant_q.push_back(3'b010);
    exp_grant_q.push_back(3'b100);
    wr_req = 1'b1; rd_req = 1'b1;
    while (exp_grant_q.size() > 0) begin
      wait_grant(40, code, at);
      exp = exp_grant_q.pop_front();
      total++; if (code !== exp) begin bad++; $display("FAIL alt_order: got %b want %b at cyc %0d", code, exp, at); end
      tick();
      if (code == 3'b010) wr_end = 1'b1;
      if (code == 3'b100) rd_end = 1'b1;
      tick();
      wr_end = 1'b0; rd_end = 1'b0;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_write_pins();
    logic [2:0] code;
    logic [17:0] exp;
    int at;
    do_reset_init();
    wr_cmd = 4'b0100; wr_addr = 12'h1FF; wr_bank = 2'd2;
    wr_req = 1'b1;
    wait_grant(20, code, at);
    total++; if (code !== 3'b010) begin bad++; $display("FAIL wr_grant: got %b want 010", code); end
    exp_pin_q.push_back({4'b0100, 12'h1FF, 2'd2});
    tick();
    exp = exp_pin_q.pop_front();
    total++; if (pins !== exp) begin bad++; $display("FAIL wr_pins1: got %h want %h", pins, exp); end
    wr_addr = 12'h0A5; wr_bank = 2'd1; wr_end = 1'b1; wr_req = 1'b0;
    exp_pin_q.push_back({4'b0100, 12'h0A5, 2'd1});
    tick();
    exp = exp_pin_q.pop_front();
    total++; if (pins !== exp) begin bad++; $display("FAIL wr_pins2: got %h want %h", pins, exp); end
    wr_end = 1'b0;
    exp_pin_q.push_back({CMD_NOP, 12'h000, 2'd0});
    tick();
    exp = exp_pin_q.pop_front();
    total++; if (pins !== exp) begin bad++; $display("FAIL wr_pins_nop: got %h want %h", pins, exp); end
    tick();
  endtask

  task automatic test_timeout();
    logic [2:0] code;
    logic early;
    int at;
    early = 1'b0;
    do_reset_init();
    rd_req = 1'b1;
    wait_grant(20, code, at);
    total++; if (code !== 3'b100) begin bad++; $display("FAIL to_rd_grant: got %b want 100", code); end
    rd_req = 1'b0;
    ref_req = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c < 17 && ref_en) early = 1'b1;
      if (c == 15) begin
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_err_early: got %b want 0", err_timeout); end
        total++; if (pins !== {CMD_RD, 12'h123, 2'd3}) begin bad++; $display("FAIL to_rd_pins: got %h want %h", pins, {CMD_RD, 12'h123, 2'd3}); end
      end
      if (c == 16) begin
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_err_set: got %b want 1", err_timeout); end
        total++; if (cmd_pins !== CMD_NOP) begin bad++; $display("FAIL to_force_nop: got %b want %b", cmd_pins, CMD_NOP); end
      end
      if (c == 17) begin
        total++; if ({ref_en, wr_en, rd_en} !== 3'b100) begin bad++; $display("FAIL to_ref_grant: got %b want 100", {ref_en, wr_en, rd_en}); end
      end
    end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL to_preempt: got %b want 0", early); end
    rd_end = 1'b1;
    tick();
    rd_end = 1'b0;
    tick();
    total++; if (cmd_pins !== CMD_AREF) begin bad++; $display("FAIL stray_end: got %b want %b", cmd_pins, CMD_AREF); end
    ref_req = 1'b0; ref_end = 1'b1;
    tick();
    ref_end = 1'b0;
    tick(); tick();
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err_timeout); end
  endtask

  task automatic test_reset_mid_write();
    logic [2:0] code;
    logic leak;
    int at, go;
    leak = 1'b0;
    wr_cmd = CMD_WR; wr_addr = 12'h1FF; wr_bank = 2'd2;
    wr_req = 1'b1;
    wait_grant(20, code, at);
    total++; if (code !== 3'b010) begin bad++; $display("FAIL mid_wr_grant: got %b want 010", code); end
    tick();
    s_rst = 1'b1;
    tick();
    total++; if ({ref_en, wr_en, rd_en} !== 3'b000) begin bad++; $display("FAIL mid_rst_en: got %b want 000", {ref_en, wr_en, rd_en}); end
    total++; if (pins !== {CMD_NOP, 12'h000, 2'd0}) begin bad++; $display("FAIL mid_rst_pins: got %h want %h", pins, {CMD_NOP, 12'h000, 2'd0}); end
    total++; if ({sdram_cke, err_timeout} !== 2'b00) begin bad++; $display("FAIL mid_rst_cke_err: got %b want 00", {sdram_cke, err_timeout}); end
    s_rst = 1'b0;
    init_end = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (wr_en) leak = 1'b1;
    end
    total++; if (leak !== 1'b0) begin bad++; $display("FAIL mid_rst_leak: got %b want 0", leak); end
    init_end = 1'b1;
    go = cyc;
    wait_grant(10, code, at);
    total++; if (code !== 3'b010) begin bad++; $display("FAIL post_init_grant: got %b want 010", code); end
    total++; if (at - go != 2) begin bad++; $display("FAIL post_init_lat: got %0d want 2", at - go); end
    wr_req = 1'b0; wr_end = 1'b1;
    tick();
    wr_end = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_alternate();
    test_write_pins();
    test_timeout();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023: max cycles any owner may hold the bus before forced release.
REQ-002 SHALL have ports sclk in 1 (sole clock, rising edge) and s_rst in 1 (reset, synchronous, active-high).
REQ-003 SHALL have port init_end in 1: init sequencer done, level.
REQ-004 SHALL have ports init_cmd in 4 and init_addr in 12: init sequencer command/address.
REQ-005 SHALL have ports ref_req in 1, ref_end in 1, ref_cmd in 4 and ref_addr in 12: refresh requester.
REQ-006 SHALL have port ref_en out 1: refresh grant pulse.
REQ-007 SHALL have ports wr_req in 1, wr_end in 1, wr_cmd in 4, wr_addr in 12 and wr_bank in 2: write requester.
REQ-008 SHALL have port wr_en out 1: write grant pulse.
REQ-009 SHALL have ports rd_req in 1, rd_end in 1, rd_cmd in 4, rd_addr in 12 and rd_bank in 2: read requester.
REQ-010 SHALL have port rd_en out 1: read grant pulse.
REQ-011 SHALL have ports sdram_cke out 1, sdram_cs_n out 1, sdram_ras_n out 1, sdram_cas_n out 1 and sdram_we_n out 1: SDRAM control pins.
REQ-012 SHALL have ports sdram_addr out 12 and sdram_ba out 2: SDRAM address and bank.
REQ-013 SHALL have port err_timeout out 1: sticky watchdog flag.

Function
REQ-014 SHALL implement states INIT, ARB, AREF, WRITE, READ, one-hot.
REQ-015 INIT -> ARB SHALL occur on the cycle after init_end=1; no grant SHALL be issued in INIT.
REQ-016 In ARB, a grant SHALL go to the highest pending source: ref_req first, then write and read by alternating priority.
REQ-017 Alternating priority: when wr_req and rd_req are both 1, the one not served most recently SHALL win; the last-served bit SHALL reset to "read" so that write wins the first tie.
REQ-018 On a grant, the arbiter SHALL move ARB -> AREF/WRITE/READ and pulse the matching *_en for exactly that one transition cycle.
REQ-019 Requests SHALL be levels held by the requester until its *_end; no request SHALL be latched inside the arbiter.
REQ-020 An owner state SHALL return to ARB on the cycle after its *_end=1; ARB SHALL then spend at least one cycle before the next grant, so back-to-back ownership has a 1-cycle NOP gap.
REQ-021 ref_req asserted during WRITE/READ SHALL NOT preempt; the owner sees ref_req itself and ends early through its own *_end.
REQ-022 {cs_n,ras_n,cas_n,we_n} SHALL be registered, 1-cycle latency, taken from init_cmd/ref_cmd/wr_cmd/rd_cmd by state, and SHALL be NOP 4'b0111 in ARB.
REQ-023 sdram_addr SHALL be registered alongside the command, from the matching source address, and 0 in ARB.
REQ-024 sdram_ba SHALL be wr_bank in WRITE, rd_bank in READ, 0 otherwise.
REQ-025 The watchdog counter SHALL clear on entry to each owner state and count each cycle spent there; at TIMEOUT it SHALL force the state to ARB, drive NOP and set err_timeout=1.
REQ-026 err_timeout SHALL be cleared only by reset.
REQ-027 *_end inputs SHALL be ignored when not in the matching state.

Reset
REQ-028 While s_rst=1 the block SHALL be in state INIT with ref_en/wr_en/rd_en=0, the command at NOP (cs_n=0, 4'b0111), sdram_addr=0, sdram_ba=0, sdram_cke=0, err_timeout=0, watchdog=0 and last-served=read.
REQ-029 sdram_cke SHALL rise to 1 on the first cycle after s_rst falls and stay at 1.
REQ-030 Reset asserted mid-burst SHALL abort on the next edge; no *_en SHALL be emitted in that cycle.

Structure
REQ-031 Shared package sdram_pkg SHALL hold the CMD_NOP/PRE/AREF/ACT/WR/RD encodings and the arbiter state encoding.
REQ-032 One sub-module, sdram_watchdog (parameterised counter with clear/enable/expire), SHALL be instantiated.
REQ-033 The command/address mux SHALL be written inline.

Verification
REQ-034 Reset, then init_end=1 at cycle 10: state reaches ARB at 11; cke=1 from cycle 1; no *_en before 12.
REQ-035 ref_req, wr_req and rd_req all 1 in ARB: ref_en pulses; after ref_end, wr_en; after wr_end, rd_en; gaps are 1 NOP cycle each.
REQ-036 wr_req and rd_req held for 4 grants: order is W, R, W, R.
REQ-037 Owner is READ and ref_req rises with no rd_end, TIMEOUT=16: forced to ARB after 16 cycles, err_timeout=1, then ref_en granted.
REQ-038 wr_cmd=4'b0100, wr_addr=0x1FF, wr_bank=2 in WRITE: same values on the pins one cycle later.
REQ-039 s_rst pulsed during WRITE: next cycle state=INIT, pins NOP, wr_en=0 until init_end.
